keycode_frame_scheduler: RTL and testbench
==========================================

# keycode_frame_scheduler

Frame-synchronous keycode scheduler between the SoC keycode PIO and the per-frame motion logic. It captures every new USB key press into a small FIFO and releases exactly one keycode per VGA frame, so presses shorter than a frame are never lost. An optional feature adds auto-repeat for held keys. It sits beside the VGA controller, consumes `VGA_VS`, and feeds the sprite/motion block in place of the raw keycode.

## Interface
- `FIFO_DEPTH`, default 4: press FIFO entries; must be a power of 2, at least 2.
- `REPEAT_DELAY`, default 15: frames a key must be held before auto-repeat starts. Range 1–255.
- `Clk`, in, 1: system clock (50 MHz). This is the only clock.
- `Reset`, in, 1: asynchronous, active-high reset.
- `keycode`, in, 8: raw keycode from the SoC PIO on the `Clk` domain; 0x00 means no key.
- `vs`, in, 1: VGA vertical sync, active low, asynchronous to `Clk` handling.
- `frame_tick`, out, 1: one-cycle pulse per frame.
- `frame_keycode`, out, 8: keycode for the current frame; 0x00 when none.
- `key_valid`, out, 1: `frame_keycode` holds a real key for this frame.
- `fifo_count`, out, $clog2(FIFO_DEPTH)+1: number of queued presses.
- `overflow`, out, 1: sticky; a press was dropped because the FIFO was full.

## Operation
- **vs sync:** 2-flop synchronizer, then a third edge-detect register. `frame_tick` = synced `vs` 0→1, i.e. the end of the sync pulse.
- **Key register:** `keycode` is registered once into `kc_r`, and the previous value is kept in `kc_p`.
- **Press event:** `kc_r != kc_p` and `kc_r != 0`. A key-to-key change with no release in between is a press. A release is not a press.
- **Push:** on a press event the keycode goes to the FIFO tail, which is circular with wrapping pointers.
- **Full:** if the FIFO is full and there is no pop in the same cycle, the press is dropped and `overflow` is set to 1 until reset.
- **Pop on `frame_tick` when the FIFO is not empty:**
  - the head goes to `frame_keycode`;
  - `key_valid` goes to 1;
  - the head pointer advances.
- **`frame_tick` with the FIFO empty:** repeat rule (see Configuration); otherwise `frame_keycode` = 0x00 and `key_valid` = 0.
- **Output hold:** `frame_keycode` and `key_valid` hold from one `frame_tick` to the next.
- **Push and pop in the same cycle:**
  - both are performed and `fifo_count` is unchanged;
  - if full, the push is accepted and there is no overflow;
  - if empty, the pop sees the pre-push state, so the pushed key is emitted on the next frame. There is no bypass.
- **`hold_cnt`** (8-bit, saturating at 255):
  - cleared whenever `kc_r != kc_p` or `kc_r == 0`;
  - otherwise incremented on each `frame_tick`.

## Timing
- **Reset values:** all outputs 0. FIFO pointers, `hold_cnt`, sync flops, `kc_r` and `kc_p` are cleared. Reset mid-frame discards all queued presses.
- **vs to tick:** a rising `vs` edge at cycle N gives `frame_tick` high in cycle N+3, for exactly 1 cycle.
- **Output latency:** `frame_keycode`, `key_valid` and `fifo_count` update at the clock edge that ends the `frame_tick` cycle, visible in cycle N+4.
- **Input latency:** a `keycode` change at cycle M is a press event in cycle M+1, and `fifo_count` increments in cycle M+2.
- **Minimum press width:** one `Clk` cycle is captured.
- **Throughput:** at most one keycode leaves per frame.

## Configuration
- **`KEY_REPEAT_EN` defined:** at a `frame_tick` with the FIFO empty, if `kc_r != 0` and `hold_cnt >= REPEAT_DELAY`, the scheduler emits `kc_r` with `key_valid` = 1. It repeats every frame while the key stays held, and a queued press always wins over a repeat.
- **`KEY_REPEAT_EN` undefined:**
  - `hold_cnt` logic is removed;
  - an empty FIFO at a tick always gives `frame_keycode` = 0x00, `key_valid` = 0;
  - the `REPEAT_DELAY` parameter is ignored.

## Test plan
- **Single press:** `keycode` 0x00→0x1A for 2 cycles → 0x00, then one `vs` rising edge → exactly one frame with `frame_keycode` = 0x1A, `key_valid` = 1. The next frame gives 0x00, `key_valid` = 0.
- **Burst:** presses 0x04, 0x07, 0x16, 0x1A within one frame → `fifo_count` = 4. The next 4 frames emit them in order, and `fifo_count` ends at 0.
- **Overflow:** 5 presses within one frame with depth 4 → `overflow` = 1 and the fifth key is never emitted. After 4 frames `overflow` is still 1; it clears only on `Reset`.
- **Simultaneous events:**
  - FIFO empty, press 0x07 in the same cycle as `frame_tick` → that frame gives 0x00, the next frame gives 0x07.
  - FIFO full, press in the same cycle as `frame_tick` → accepted, `overflow` = 0.
- **Auto-repeat** (with `KEY_REPEAT_EN`, `REPEAT_DELAY` = 3): hold 0x1A across 8 frames → frame 1 = press; frames 2–3 = 0x00; frames 4–8 = 0x1A. Without the macro, frames 2–8 are 0x00.
- **Reset:** 3 presses queued, then `Reset` pulsed mid-frame → all outputs 0 immediately (async), and the next frame gives `key_valid` = 0.

Source files
------------

// File: rtl/keycode_frame_scheduler_if.sv
// Keycode scheduler bus: raw keycode and vsync in, per-frame keycode and FIFO status out.
// The master side is the SoC/VGA side and the slave side is the scheduler.
interface keycode_frame_scheduler_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    keycode;
    logic          vs;
    logic          frame_tick;
    logic [7:0]    frame_keycode;
    logic          key_valid;
    logic [CW-1:0] fifo_count;
    logic          overflow;

    modport master (
        output keycode, vs,
        input  frame_tick, frame_keycode, key_valid, fifo_count, overflow
    );

    modport slave (
        input  keycode, vs,
        output frame_tick, frame_keycode, key_valid, fifo_count, overflow
    );
endinterface

// File: rtl/keycode_frame_scheduler.sv
// Queues every new key press and releases at most one keycode per VGA frame.
// Auto-repeat for held keys is built only when KEY_REPEAT_EN is defined.
module keycode_frame_scheduler #(
    parameter int FIFO_DEPTH   = 4,
    parameter int REPEAT_DELAY = 15
) (
    input logic Clk,
    input logic Reset,
    keycode_frame_scheduler_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end
    if (REPEAT_DELAY < 1 || REPEAT_DELAY > 255) begin : g_delay_chk
        $error("REPEAT_DELAY must be in 1..255");
    end

    logic          vs_s1, vs_s2, vs_s3;
    logic          tick;
    logic [7:0]    kc_r, kc_p;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          empty, full, press, pop, push, drop;
    logic          rep_ok;
    logic [7:0]    frame_kc;
    logic          kc_valid;
    logic          ovf;

    assign count = wr_ptr - rd_ptr;
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign press = (kc_r != kc_p) && (kc_r != 8'h00);
    assign pop   = tick && !empty;
    // A pop in the same cycle frees a slot, so a press against a full FIFO still fits.
    assign push  = press && (!full || pop);
    assign drop  = press && full && !pop;

`ifdef KEY_REPEAT_EN
    logic [7:0] hold_cnt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hold_cnt <= 8'h00;
        end else if ((kc_r != kc_p) || (kc_r == 8'h00)) begin
            hold_cnt <= 8'h00;
        end else if (tick && (hold_cnt != 8'hFF)) begin
            hold_cnt <= hold_cnt + 8'h01;
        end
    end

    assign rep_ok = (kc_r != 8'h00) && (hold_cnt >= 8'(REPEAT_DELAY));
`else
    assign rep_ok = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= kc_r;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            vs_s1    <= 1'b0;
            vs_s2    <= 1'b0;
            vs_s3    <= 1'b0;
            tick     <= 1'b0;
            kc_r     <= 8'h00;
            kc_p     <= 8'h00;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            frame_kc <= 8'h00;
            kc_valid <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            vs_s1 <= bus.vs;
            vs_s2 <= vs_s1;
            vs_s3 <= vs_s2;
            tick  <= vs_s2 && !vs_s3;
            kc_r  <= bus.keycode;
            kc_p  <= kc_r;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (drop) begin
                ovf <= 1'b1;
            end
            if (tick) begin
                if (!empty) begin
                    frame_kc <= mem[rd_ptr[AW-1:0]];
                    kc_valid <= 1'b1;
                    rd_ptr   <= rd_ptr + 1'b1;
                end else if (rep_ok) begin
                    frame_kc <= kc_r;
                    kc_valid <= 1'b1;
                end else begin
                    frame_kc <= 8'h00;
                    kc_valid <= 1'b0;
                end
            end
        end
    end

    assign bus.frame_tick    = tick;
    assign bus.frame_keycode = frame_kc;
    assign bus.key_valid     = kc_valid;
    assign bus.fifo_count    = count;
    assign bus.overflow      = ovf;
endmodule

// File: tb/tb_keycode_frame_scheduler.sv
// Self-checking bench for keycode_frame_scheduler; expected frame outputs go through a scoreboard queue.
// Auto-repeat expectations follow KEY_REPEAT_EN when the bench is built with it.
module tb_keycode_frame_scheduler;
    localparam int DEPTH = 4;
    localparam int RDLY  = 3;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;
    logic [8:0] sb [$];

    keycode_frame_scheduler_if #(.FIFO_DEPTH(DEPTH)) bus ();

    keycode_frame_scheduler #(
        .FIFO_DEPTH  (DEPTH),
        .REPEAT_DELAY(RDLY)
    ) dut (
        .Clk  (clk),
        .Reset(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic press(input logic [7:0] k, input int width);
        @(posedge clk); #1 bus.keycode = k;
        repeat (width) @(posedge clk);
        #1 bus.keycode = 8'h00;
        @(posedge clk);
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    // Drives one vsync pulse and returns the frame outputs seen just after the tick.
    task automatic do_frame(output logic [8:0] got, output bit ok);
        ok = 1'b0;
        @(posedge clk); #1 bus.vs = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.vs = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.frame_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
        got = {bus.key_valid, bus.frame_keycode};
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    task automatic run_frames(input string name, input int n);
        logic [8:0] got, exp;
        bit ok;
        for (int i = 0; i < n; i++) begin
            do_frame(got, ok);
            exp = sb.pop_front();
            total_cnt++;
            if (!ok) $display("FAIL %s frame %0d: frame_tick not seen within budget, expected %h", name, i, exp);
            else if (got !== exp) $display("FAIL %s frame %0d: got {valid,key}=%h expected %h", name, i, got, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        bus.keycode = 8'h00;
        bus.vs      = 1'b1;
        rst         = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if ({bus.frame_tick, bus.key_valid, bus.frame_keycode, bus.fifo_count, bus.overflow} !== 21'h0)
            $display("FAIL reset_state: got tick=%b valid=%b key=%h count=%0d ovf=%b expected all 0",
                     bus.frame_tick, bus.key_valid, bus.frame_keycode, bus.fifo_count, bus.overflow);
        else pass_cnt++;
        #1 rst = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    task automatic test_single_press();
        press(8'h1A, 2);
        settle();
        total_cnt++;
        if (bus.fifo_count !== 3'd1) $display("FAIL single_count: got %0d expected 1", bus.fifo_count);
        else pass_cnt++;
        sb.push_back({1'b1, 8'h1A});
        sb.push_back({1'b0, 8'h00});
        run_frames("single", 2);
    endtask

    task automatic test_burst();
        logic [7:0] keys [4] = '{8'h04, 8'h07, 8'h16, 8'h1A};
        foreach (keys[i]) begin
            press(keys[i], 1);
            sb.push_back({1'b1, keys[i]});
        end
        settle();
        total_cnt++;
        if (bus.fifo_count !== 3'd4) $display("FAIL burst_count: got %0d expected 4", bus.fifo_count);
        else pass_cnt++;
        run_frames("burst", 4);
        total_cnt++;
        if (bus.fifo_count !== 3'd0) $display("FAIL burst_drain: got %0d expected 0", bus.fifo_count);
        else pass_cnt++;
    endtask

    // Lines up a press event with the cycle frame_tick is high.
    task automatic simul_frame(input logic [7:0] k, input logic [8:0] exp_out, input logic [2:0] exp_cnt);
        @(posedge clk); #1 bus.vs = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.vs = 1'b1;
        repeat (2) @(posedge clk);
        #1 bus.keycode = k;
        @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (bus.frame_tick !== 1'b1) $display("FAIL simul_align: got tick=%b expected 1", bus.frame_tick);
        else pass_cnt++;
        bus.keycode = 8'h00;
        @(negedge clk);
        total_cnt++;
        if ({bus.key_valid, bus.frame_keycode} !== exp_out)
            $display("FAIL simul_out: got %h expected %h", {bus.key_valid, bus.frame_keycode}, exp_out);
        else pass_cnt++;
        total_cnt++;
        if (bus.fifo_count !== exp_cnt || bus.overflow !== 1'b0)
            $display("FAIL simul_count: got count=%0d ovf=%b expected count=%0d ovf=0",
                     bus.fifo_count, bus.overflow, exp_cnt);
        else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        simul_frame(8'h07, {1'b0, 8'h00}, 3'd1);
        sb.push_back({1'b1, 8'h07});
        run_frames("simul_empty", 1);
        for (int i = 0; i < 4; i++) begin
            press(8'h21 + 8'(i), 1);
        end
        settle();
        total_cnt++;
        if (bus.fifo_count !== 3'd4) $display("FAIL simul_fill: got %0d expected 4", bus.fifo_count);
        else pass_cnt++;
        simul_frame(8'h09, {1'b1, 8'h21}, 3'd4);
        sb.push_back({1'b1, 8'h22});
        sb.push_back({1'b1, 8'h23});
        sb.push_back({1'b1, 8'h24});
        sb.push_back({1'b1, 8'h09});
        run_frames("simul_full", 4);
    endtask

    task automatic test_repeat();
        @(posedge clk); #1 bus.keycode = 8'h1A;
        repeat (4) @(posedge clk);
        sb.push_back({1'b1, 8'h1A});
        for (int f = 2; f <= 8; f++) begin
`ifdef KEY_REPEAT_EN
            sb.push_back((f > RDLY) ? {1'b1, 8'h1A} : {1'b0, 8'h00});
`else
            sb.push_back({1'b0, 8'h00});
`endif
        end
        run_frames("repeat", 8);
        #1 bus.keycode = 8'h00;
        repeat (3) @(posedge clk);
        sb.push_back({1'b0, 8'h00});
        run_frames("repeat_release", 1);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) begin
            press(8'h31 + 8'(i), 1);
            if (i < 4) sb.push_back({1'b1, 8'h31 + 8'(i)});
        end
        settle();
        total_cnt++;
        if (bus.fifo_count !== 3'd4 || bus.overflow !== 1'b1)
            $display("FAIL ovf_set: got count=%0d ovf=%b expected count=4 ovf=1", bus.fifo_count, bus.overflow);
        else pass_cnt++;
        run_frames("ovf_drain", 4);
        total_cnt++;
        if (bus.overflow !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", bus.overflow);
        else pass_cnt++;
        sb.push_back({1'b0, 8'h00});
        run_frames("ovf_fifth", 1);
    endtask

    task automatic test_reset_mid_frame();
        press(8'h41, 1);
        press(8'h42, 1);
        press(8'h43, 1);
        sb.push_back({1'b1, 8'h41});
        run_frames("rst_pre", 1);
        press(8'h44, 1);
        settle();
        total_cnt++;
        if (bus.fifo_count !== 3'd3) $display("FAIL rst_queued: got %0d expected 3", bus.fifo_count);
        else pass_cnt++;
        @(posedge clk); #3 rst = 1'b1;
        #1;
        total_cnt++;
        if ({bus.key_valid, bus.frame_keycode, bus.fifo_count, bus.overflow} !== 13'h0)
            $display("FAIL rst_async: got valid=%b key=%h count=%0d ovf=%b expected all 0",
                     bus.key_valid, bus.frame_keycode, bus.fifo_count, bus.overflow);
        else pass_cnt++;
        @(posedge clk); #1 rst = 1'b0;
        repeat (6) @(posedge clk);
        sb.push_back({1'b0, 8'h00});
        run_frames("rst_post", 1);
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_single_press();
        test_burst();
        test_simultaneous();
        test_repeat();
        test_overflow();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end
endmodule
